// File: rtl/pcie_cpl_tag_tracker.sv
// -----------------------------------------------------------------------------
// pcie_cpl_tag_tracker
//
// Tracks outstanding PCIe read requests by tag. Each completion is annotated
// with the request's user context and its byte offset within the request.
// When the final completion of a request arrives, the tag is retired and
// handed back to the tag allocator.
//
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   s_req_*               : issued read request (tag, byte count, context);
//                           always ready
//   s_cpl_*               : received completion (tag, payload bytes)
//   m_cpl_*               : annotated completion (tag, ctx, offset, last, err),
//                           registered, one cycle after acceptance
//   m_tag_free_*          : retired tag returned to the allocator
//   outstanding           : number of currently active tags
//   err_sticky            : any protocol error seen since reset
// -----------------------------------------------------------------------------
module pcie_cpl_tag_tracker #(
    parameter int PCIE_TAG_BITS = 5,
    parameter int CTX_WIDTH     = 16,
    parameter int BC_BITS       = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PCIE_TAG_BITS-1:0] s_req_tag,
    input  logic [BC_BITS-1:0]       s_req_bytes,
    input  logic [CTX_WIDTH-1:0]     s_req_ctx,
    input  logic                     s_req_valid,
    output logic                     s_req_ready,
    input  logic [PCIE_TAG_BITS-1:0] s_cpl_tag,
    input  logic [BC_BITS-1:0]       s_cpl_bytes,
    input  logic                     s_cpl_valid,
    output logic                     s_cpl_ready,
    output logic [PCIE_TAG_BITS-1:0] m_cpl_tag,
    output logic [CTX_WIDTH-1:0]     m_cpl_ctx,
    output logic [BC_BITS-1:0]       m_cpl_offset,
    output logic                     m_cpl_last,
    output logic                     m_cpl_err,
    output logic                     m_cpl_valid,
    input  logic                     m_cpl_ready,
    output logic [PCIE_TAG_BITS-1:0] m_tag_free_data,
    output logic                     m_tag_free_valid,
    input  logic                     m_tag_free_ready,
    output logic [PCIE_TAG_BITS:0]   outstanding,
    output logic                     err_sticky
);

    localparam int NTAGS = 1 << PCIE_TAG_BITS;
    localparam logic [PCIE_TAG_BITS:0] OUT_ONE = 1;

    // Per-tag table. Only the active bits need reset; the data fields are
    // always rewritten when a tag is (re)activated.
    logic [NTAGS-1:0]     r_active;
    logic [BC_BITS-1:0]   r_remain [NTAGS];
    logic [BC_BITS-1:0]   r_offset [NTAGS];
    logic [CTX_WIDTH-1:0] r_ctx    [NTAGS];

    logic                     r_cpl_valid;
    logic [PCIE_TAG_BITS-1:0] r_cpl_tag;
    logic [CTX_WIDTH-1:0]     r_cpl_ctx;
    logic [BC_BITS-1:0]       r_cpl_offset;
    logic                     r_cpl_last;
    logic                     r_cpl_err;
    logic                     r_free_valid;
    logic [PCIE_TAG_BITS-1:0] r_free_data;
    logic [PCIE_TAG_BITS:0]   r_outstanding;
    logic                     r_err_sticky;

    logic                 w_cpl_ready;
    logic                 w_cpl_fire;
    logic                 w_cpl_active;
    logic [BC_BITS-1:0]   w_cpl_remain;
    logic                 w_cpl_err;
    logic                 w_cpl_last;
    logic                 w_cpl_upd;
    logic                 w_retire;
    logic                 w_req_ok;
    logic                 w_req_err;

    // A completion may only be taken when both output slots can accept a new
    // value this cycle, since a last completion loads both at once.
    assign w_cpl_ready  = (!r_cpl_valid || m_cpl_ready) && (!r_free_valid || m_tag_free_ready);
    assign w_cpl_fire   = s_cpl_valid && w_cpl_ready;

    // All lookups use the table state before this cycle's request is applied.
    assign w_cpl_active = r_active[s_cpl_tag];
    assign w_cpl_remain = r_remain[s_cpl_tag];
    assign w_cpl_err    = !w_cpl_active || (s_cpl_bytes == '0) || (s_cpl_bytes > w_cpl_remain);
    assign w_cpl_last   = !w_cpl_err && (s_cpl_bytes == w_cpl_remain);
    assign w_cpl_upd    = w_cpl_fire && !w_cpl_err;
    assign w_retire     = w_cpl_upd && w_cpl_last;

    // A tag being retired this cycle is still active here, so a request to
    // it is rejected.
    assign w_req_ok     = s_req_valid && !r_active[s_req_tag] && (s_req_bytes != '0);
    assign w_req_err    = s_req_valid && !w_req_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= '0;
        end else begin
            if (w_retire) r_active[s_cpl_tag] <= 1'b0;
            if (w_req_ok) r_active[s_req_tag] <= 1'b1;
        end
    end

    // A valid completion needs an active tag and a new request needs an
    // inactive one, so the two writes below never target the same entry.
    always_ff @(posedge clk) begin
        if (w_cpl_upd) begin
            r_remain[s_cpl_tag] <= w_cpl_remain - s_cpl_bytes;
            r_offset[s_cpl_tag] <= r_offset[s_cpl_tag] + s_cpl_bytes;
        end
        if (w_req_ok) begin
            r_remain[s_req_tag] <= s_req_bytes;
            r_offset[s_req_tag] <= '0;
            r_ctx[s_req_tag]    <= s_req_ctx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpl_valid   <= 1'b0;
            r_cpl_tag     <= '0;
            r_cpl_ctx     <= '0;
            r_cpl_offset  <= '0;
            r_cpl_last    <= 1'b0;
            r_cpl_err     <= 1'b0;
            r_free_valid  <= 1'b0;
            r_free_data   <= '0;
            r_outstanding <= '0;
            r_err_sticky  <= 1'b0;
        end else begin
            if (w_cpl_fire) begin
                r_cpl_valid  <= 1'b1;
                r_cpl_tag    <= s_cpl_tag;
                r_cpl_ctx    <= r_ctx[s_cpl_tag];
                r_cpl_offset <= r_offset[s_cpl_tag];
                r_cpl_last   <= w_cpl_last;
                r_cpl_err    <= w_cpl_err;
            end else if (m_cpl_ready) begin
                r_cpl_valid  <= 1'b0;
            end

            if (w_retire) begin
                r_free_valid <= 1'b1;
                r_free_data  <= s_cpl_tag;
            end else if (m_tag_free_ready) begin
                r_free_valid <= 1'b0;
            end

            case ({w_req_ok, w_retire})
                2'b10:   r_outstanding <= r_outstanding + OUT_ONE;
                2'b01:   r_outstanding <= r_outstanding - OUT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase

            if (w_req_err || (w_cpl_fire && w_cpl_err)) r_err_sticky <= 1'b1;
        end
    end

    assign s_req_ready      = 1'b1;
    assign s_cpl_ready      = w_cpl_ready;
    assign m_cpl_valid      = r_cpl_valid;
    assign m_cpl_tag        = r_cpl_tag;
    assign m_cpl_ctx        = r_cpl_ctx;
    assign m_cpl_offset     = r_cpl_offset;
    assign m_cpl_last       = r_cpl_last;
    assign m_cpl_err        = r_cpl_err;
    assign m_tag_free_valid = r_free_valid;
    assign m_tag_free_data  = r_free_data;
    assign outstanding      = r_outstanding;
    assign err_sticky       = r_err_sticky;

endmodule

// File: tb/tb_pcie_cpl_tag_tracker.sv
// -----------------------------------------------------------------------------
// tb_pcie_cpl_tag_tracker
//
// Bench for pcie_cpl_tag_tracker: a reset check, a table of directed vectors,
// hand-written multi-cycle sequences (backpressure, 32-tag shuffle, reset
// mid-operation, same-cycle request/retire) and a randomized phase. A
// transaction-level reference model (per-tag arrays plus expected-output
// queues) runs on every falling edge.
// -----------------------------------------------------------------------------
module tb_pcie_cpl_tag_tracker;

    localparam int TAGW = 5;
    localparam int CW   = 16;
    localparam int BW   = 13;
    localparam int NT   = 32;

    logic            clk;
    logic            rst_n;
    logic [TAGW-1:0] s_req_tag;
    logic [BW-1:0]   s_req_bytes;
    logic [CW-1:0]   s_req_ctx;
    logic            s_req_valid;
    logic            s_req_ready;
    logic [TAGW-1:0] s_cpl_tag;
    logic [BW-1:0]   s_cpl_bytes;
    logic            s_cpl_valid;
    logic            s_cpl_ready;
    logic [TAGW-1:0] m_cpl_tag;
    logic [CW-1:0]   m_cpl_ctx;
    logic [BW-1:0]   m_cpl_offset;
    logic            m_cpl_last;
    logic            m_cpl_err;
    logic            m_cpl_valid;
    logic            m_cpl_ready;
    logic [TAGW-1:0] m_tag_free_data;
    logic            m_tag_free_valid;
    logic            m_tag_free_ready;
    logic [TAGW:0]   outstanding;
    logic            err_sticky;

    pcie_cpl_tag_tracker #(.PCIE_TAG_BITS(TAGW), .CTX_WIDTH(CW), .BC_BITS(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req_tag(s_req_tag), .s_req_bytes(s_req_bytes), .s_req_ctx(s_req_ctx),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
        .s_cpl_tag(s_cpl_tag), .s_cpl_bytes(s_cpl_bytes),
        .s_cpl_valid(s_cpl_valid), .s_cpl_ready(s_cpl_ready),
        .m_cpl_tag(m_cpl_tag), .m_cpl_ctx(m_cpl_ctx), .m_cpl_offset(m_cpl_offset),
        .m_cpl_last(m_cpl_last), .m_cpl_err(m_cpl_err),
        .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready),
        .m_tag_free_data(m_tag_free_data), .m_tag_free_valid(m_tag_free_valid),
        .m_tag_free_ready(m_tag_free_ready),
        .outstanding(outstanding), .err_sticky(err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int tag;
        int ctx;
        int off;
        bit last;
        bit err;
    } exp_t;

    bit   mact [NT];
    int   mrem [NT];
    int   moff [NT];
    int   mctx [NT];
    int   mout;
    bit   msticky;
    exp_t qc[$];
    int   qf[$];
    int   freecnt [NT];

    always @(negedge clk) begin
        exp_t e;
        int   t;
        int   b;
        int   ft;
        bit   exp_rdy;
        bit   req_ok;
        if (!rst_n) begin
            for (int i = 0; i < NT; i++) mact[i] = 1'b0;
            mout    = 0;
            msticky = 1'b0;
            qc.delete();
            qf.delete();
        end else begin
            chk("m_cpl_valid", m_cpl_valid, qc.size() != 0);
            chk("m_tag_free_valid", m_tag_free_valid, qf.size() != 0);
            exp_rdy = (qc.size() == 0 || m_cpl_ready) && (qf.size() == 0 || m_tag_free_ready);
            chk("s_cpl_ready", s_cpl_ready, exp_rdy);
            chk("s_req_ready", s_req_ready, 1);
            chk("outstanding", outstanding, mout);
            chk("err_sticky", err_sticky, msticky);

            if (m_cpl_valid && m_cpl_ready && qc.size() > 0) begin
                e = qc.pop_front();
                chk("m_cpl_tag", m_cpl_tag, e.tag);
                chk("m_cpl_err", m_cpl_err, e.err);
                chk("m_cpl_last", m_cpl_last, e.last);
                if (!e.err) begin
                    chk("m_cpl_ctx", m_cpl_ctx, e.ctx);
                    chk("m_cpl_offset", m_cpl_offset, e.off);
                end
            end
            if (m_tag_free_valid && m_tag_free_ready && qf.size() > 0) begin
                ft = qf.pop_front();
                chk("m_tag_free_data", m_tag_free_data, ft);
                freecnt[m_tag_free_data]++;
            end

            // Request legality is judged on the table as it stood before this cycle.
            req_ok = s_req_valid && !mact[s_req_tag] && (s_req_bytes != 0);
            if (s_req_valid && !req_ok) msticky = 1'b1;

            if (s_cpl_valid && exp_rdy) begin
                t     = int'(s_cpl_tag);
                b     = int'(s_cpl_bytes);
                e.tag = t;
                e.ctx = mctx[t];
                e.off = moff[t];
                e.err = !mact[t] || b == 0 || b > mrem[t];
                e.last = !e.err && b == mrem[t];
                if (e.err) begin
                    msticky = 1'b1;
                end else begin
                    mrem[t] = mrem[t] - b;
                    moff[t] = (moff[t] + b) % (1 << BW);
                    if (e.last) begin
                        mact[t] = 1'b0;
                        qf.push_back(t);
                        mout--;
                    end
                end
                qc.push_back(e);
            end

            if (req_ok) begin
                mact[s_req_tag] = 1'b1;
                mrem[s_req_tag] = int'(s_req_bytes);
                moff[s_req_tag] = 0;
                mctx[s_req_tag] = int'(s_req_ctx);
                mout++;
            end
        end
    end

    // ---------------- ready randomizer ----------------
    bit rand_rdy = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                m_cpl_ready      = ($urandom % 2) != 0;
                m_tag_free_ready = ($urandom % 3) != 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int t, input int b, input int c);
        s_req_valid = 1'b1;
        s_req_tag   = TAGW'(t);
        s_req_bytes = BW'(b);
        s_req_ctx   = CW'(c);
        tick();
        s_req_valid = 1'b0;
    endtask

    // Holds the completion until it is taken; returns just after the taking edge.
    task automatic send_cpl(input int t, input int b);
        int g;
        bit acc;
        s_cpl_valid = 1'b1;
        s_cpl_tag   = TAGW'(t);
        s_cpl_bytes = BW'(b);
        g   = 0;
        acc = 1'b0;
        while (!acc && g < 200) begin
            @(negedge clk);
            acc = s_cpl_ready;
            @(posedge clk);
            #1;
            g++;
        end
        s_cpl_valid = 1'b0;
        chk("cpl_accept", acc, 1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit rv; int rtag; int rbytes; int rctx;
        bit cv; int ctag; int cbytes;
        bit ev; int etag; int eoff; int ectx; bit elast; bit eerr;
        bit efv; int efd; int eout; bit esticky;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int order [NT];
        int j;
        int tmp;
        int ct;
        int b;

        rst_n = 1'b0;
        s_req_valid = 1'b0; s_req_tag = '0; s_req_bytes = '0; s_req_ctx = '0;
        s_cpl_valid = 1'b0; s_cpl_tag = '0; s_cpl_bytes = '0;
        m_cpl_ready = 1'b1; m_tag_free_ready = 1'b1;
        for (int i = 0; i < NT; i++) freecnt[i] = 0;

        //             rv tag bytes ctx     cv tag bytes ev tag off ctx     last err fv fd out st
        tbl[0] = '{1, 3, 256, 'hABCD, 0, 0,  0,  0, 0, 0,   0,      0, 0, 0, 0, 1, 0};
        tbl[1] = '{0, 0, 0,   0,      1, 3,  64, 1, 3, 0,   'hABCD, 0, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 0, 0,   0,      1, 3, 128, 1, 3, 64,  'hABCD, 0, 0, 0, 0, 1, 0};
        tbl[3] = '{0, 0, 0,   0,      1, 3,  64, 1, 3, 192, 'hABCD, 1, 0, 1, 3, 0, 0};
        tbl[4] = '{0, 0, 0,   0,      0, 0,  0,  0, 0, 0,   0,      0, 0, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 0,   0,      1, 7,  8,  1, 7, 0,   0,      0, 1, 0, 0, 0, 1};
        tbl[6] = '{0, 0, 0,   0,      0, 0,  0,  0, 0, 0,   0,      0, 0, 0, 0, 0, 1};

        // ---- reset state ----
        repeat (3) tick();
        chk("rst_m_cpl_valid", m_cpl_valid, 0);
        chk("rst_m_tag_free_valid", m_tag_free_valid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err_sticky", err_sticky, 0);
        chk("rst_m_cpl_tag", m_cpl_tag, 0);
        chk("rst_m_cpl_ctx", m_cpl_ctx, 0);
        chk("rst_m_cpl_offset", m_cpl_offset, 0);
        chk("rst_m_cpl_last", m_cpl_last, 0);
        chk("rst_m_cpl_err", m_cpl_err, 0);
        chk("rst_m_tag_free_data", m_tag_free_data, 0);
        rst_n = 1'b1;

        // ---- table: split completions, then completion to an inactive tag ----
        for (int i = 0; i < 7; i++) begin
            s_req_valid = tbl[i].rv;
            s_req_tag   = TAGW'(tbl[i].rtag);
            s_req_bytes = BW'(tbl[i].rbytes);
            s_req_ctx   = CW'(tbl[i].rctx);
            s_cpl_valid = tbl[i].cv;
            s_cpl_tag   = TAGW'(tbl[i].ctag);
            s_cpl_bytes = BW'(tbl[i].cbytes);
            tick();
            chk($sformatf("vec%0d_cpl_valid", i), m_cpl_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_cpl_tag", i), m_cpl_tag, tbl[i].etag);
                chk($sformatf("vec%0d_cpl_last", i), m_cpl_last, tbl[i].elast);
                chk($sformatf("vec%0d_cpl_err", i), m_cpl_err, tbl[i].eerr);
                if (!tbl[i].eerr) begin
                    chk($sformatf("vec%0d_cpl_offset", i), m_cpl_offset, tbl[i].eoff);
                    chk($sformatf("vec%0d_cpl_ctx", i), m_cpl_ctx, tbl[i].ectx);
                end
            end
            chk($sformatf("vec%0d_free_valid", i), m_tag_free_valid, tbl[i].efv);
            if (tbl[i].efv) chk($sformatf("vec%0d_free_data", i), m_tag_free_data, tbl[i].efd);
            chk($sformatf("vec%0d_outstanding", i), outstanding, tbl[i].eout);
            chk($sformatf("vec%0d_err_sticky", i), err_sticky, tbl[i].esticky);
        end
        s_req_valid = 1'b0;
        s_cpl_valid = 1'b0;

        // ---- backpressure on both outputs with a last completion pending ----
        m_cpl_ready = 1'b0;
        m_tag_free_ready = 1'b0;
        send_req(9, 16, 'h1234);
        s_cpl_valid = 1'b1; s_cpl_tag = TAGW'(9); s_cpl_bytes = BW'(16);
        tick();
        s_cpl_bytes = BW'(4);
        for (int k = 0; k < 4; k++) begin
            chk("bp_s_cpl_ready", s_cpl_ready, 0);
            chk("bp_cpl_valid", m_cpl_valid, 1);
            chk("bp_cpl_tag", m_cpl_tag, 9);
            chk("bp_cpl_last", m_cpl_last, 1);
            chk("bp_cpl_offset", m_cpl_offset, 0);
            chk("bp_cpl_ctx", m_cpl_ctx, 'h1234);
            chk("bp_free_valid", m_tag_free_valid, 1);
            chk("bp_free_data", m_tag_free_data, 9);
            tick();
        end
        m_cpl_ready = 1'b1;
        tick();
        chk("bp_cpl_drained", m_cpl_valid, 0);
        chk("bp_free_held", m_tag_free_valid, 1);
        chk("bp_ready_still_low", s_cpl_ready, 0);
        m_tag_free_ready = 1'b1;
        tick();
        chk("bp_free_drained", m_tag_free_valid, 0);
        chk("bp_ready_back", s_cpl_ready, 1);
        s_cpl_valid = 1'b0;
        chk("bp_outstanding", outstanding, 0);

        // ---- all 32 tags, completed in shuffled order under random readies ----
        for (int i = 0; i < NT; i++) begin
            freecnt[i] = 0;
            order[i] = i;
        end
        rand_rdy = 1'b1;
        for (int t = 0; t < NT; t++) send_req(t, 4, t * 3);
        tick();
        chk("all_outstanding_full", outstanding, 32);
        for (int i = NT - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            tmp = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        for (int i = 0; i < NT; i++) send_cpl(order[i], 4);
        rand_rdy = 1'b0;
        tick();
        m_cpl_ready = 1'b1;
        m_tag_free_ready = 1'b1;
        repeat (4) tick();
        chk("all_outstanding_empty", outstanding, 0);
        for (int t = 0; t < NT; t++) chk($sformatf("all_free_count_tag%0d", t), freecnt[t], 1);

        // ---- reset with 4 tags active ----
        for (int t = 0; t < 4; t++) send_req(t, 32, 'h100 + t);
        tick();
        chk("rst4_outstanding_before", outstanding, 4);
        for (int i = 0; i < NT; i++) freecnt[i] = 0;
        rst_n = 1'b0;
        #2;
        chk("rst4_outstanding_async", outstanding, 0);
        chk("rst4_sticky_async", err_sticky, 0);
        chk("rst4_cpl_valid_async", m_cpl_valid, 0);
        chk("rst4_free_valid_async", m_tag_free_valid, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rst4_no_free_after", m_tag_free_valid, 0);
        end
        send_req(0, 8, 'h55AA);
        chk("rst4_new_outstanding", outstanding, 1);
        chk("rst4_new_sticky", err_sticky, 0);
        send_cpl(0, 8);
        chk("rst4_new_cpl_valid", m_cpl_valid, 1);
        chk("rst4_new_cpl_last", m_cpl_last, 1);
        chk("rst4_new_cpl_err", m_cpl_err, 0);
        chk("rst4_new_cpl_ctx", m_cpl_ctx, 'h55AA);
        chk("rst4_new_cpl_offset", m_cpl_offset, 0);
        chk("rst4_new_free_valid", m_tag_free_valid, 1);
        chk("rst4_new_free_data", m_tag_free_data, 0);
        tick();
        chk("rst4_new_outstanding_end", outstanding, 0);

        // ---- request to tag 5 in the same cycle as its last completion ----
        chk("same_sticky_before", err_sticky, 0);
        send_req(5, 16, 'h0505);
        s_cpl_valid = 1'b1; s_cpl_tag = TAGW'(5); s_cpl_bytes = BW'(16);
        s_req_valid = 1'b1; s_req_tag = TAGW'(5); s_req_bytes = BW'(8); s_req_ctx = CW'('h0606);
        tick();
        s_cpl_valid = 1'b0;
        s_req_valid = 1'b0;
        chk("same_cpl_last", m_cpl_last, 1);
        chk("same_cpl_err", m_cpl_err, 0);
        chk("same_free_valid", m_tag_free_valid, 1);
        chk("same_free_data", m_tag_free_data, 5);
        chk("same_sticky_after", err_sticky, 1);
        repeat (3) tick();
        chk("same_outstanding", outstanding, 0);
        chk("same_free_once", freecnt[5], 1);

        // Completion for a tag that was active before reset must now error.
        send_cpl(1, 32);
        chk("stale_cpl_err", m_cpl_err, 1);
        chk("stale_cpl_last", m_cpl_last, 0);
        chk("stale_no_free", m_tag_free_valid, 0);

        // ---- randomized traffic against the model ----
        rand_rdy = 1'b1;
        for (int c = 0; c < 600; c++) begin
            s_req_valid = ($urandom % 10) < 3;
            s_req_tag   = TAGW'($urandom % 8);
            s_req_bytes = (($urandom % 10) == 0) ? BW'(0) : BW'($urandom_range(64, 1));
            s_req_ctx   = CW'($urandom);
            s_cpl_valid = ($urandom % 10) < 6;
            ct = int'($urandom % 8);
            if (mact[ct]) begin
                case ($urandom % 6)
                    0, 1, 2: b = mrem[ct];
                    3:       b = int'($urandom_range(mrem[ct], 1));
                    4:       b = mrem[ct] + 1;
                    default: b = 0;
                endcase
            end else begin
                b = int'($urandom_range(16, 1));
            end
            s_cpl_tag   = TAGW'(ct);
            s_cpl_bytes = BW'(b);
            tick();
        end
        s_req_valid = 1'b0;
        s_cpl_valid = 1'b0;
        rand_rdy = 1'b0;
        tick();
        m_cpl_ready = 1'b1;
        m_tag_free_ready = 1'b1;
        repeat (4) tick();
        chk("rand_cpl_drained", m_cpl_valid, 0);
        chk("rand_free_drained", m_tag_free_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_cpl_tag_tracker.md
PCIE_CPL_TAG_TRACKER -- requirements
Module: pcie_cpl_tag_tracker

Interface
REQ-001 SHALL have parameter PCIE_TAG_BITS, default 5, giving the tag width; the table holds 2^PCIE_TAG_BITS entries.
REQ-002 SHALL have parameter CTX_WIDTH, default 16, giving the width of the per-request user context.
REQ-003 SHALL have parameter BC_BITS, default 13, giving the byte-count width (max request 4096 bytes).
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst_n, input, 1: the reset, asynchronous and active-low.
REQ-006 SHALL have ports s_req_tag/s_req_bytes/s_req_ctx, input, PCIE_TAG_BITS/BC_BITS/CTX_WIDTH: the issued read request.
REQ-007 SHALL have ports s_req_valid (input, 1) and s_req_ready (output, 1): the request handshake.
REQ-008 SHALL have ports s_cpl_tag/s_cpl_bytes, input, PCIE_TAG_BITS/BC_BITS: the received completion's tag and payload bytes.
REQ-009 SHALL have ports s_cpl_valid (input, 1) and s_cpl_ready (output, 1): the completion handshake.
REQ-010 SHALL have ports m_cpl_tag/m_cpl_ctx/m_cpl_offset, output, PCIE_TAG_BITS/CTX_WIDTH/BC_BITS: the annotated completion.
REQ-011 SHALL have ports m_cpl_last and m_cpl_err, output, 1 each: last completion of the request, and protocol error.
REQ-012 SHALL have ports m_cpl_valid (output, 1) and m_cpl_ready (input, 1): the annotated-completion handshake.
REQ-013 SHALL have ports m_tag_free_data (output, PCIE_TAG_BITS), m_tag_free_valid (output, 1) and m_tag_free_ready (input, 1): the retired tag returned to the allocator.
REQ-014 SHALL have port outstanding, output, PCIE_TAG_BITS+1: the count of active tags.
REQ-015 SHALL have port err_sticky, output, 1: set on any error, cleared only by reset.

Function
REQ-016 SHALL keep one table entry per tag: active bit, remaining bytes (BC_BITS), offset (BC_BITS), ctx.
REQ-017 SHALL tie s_req_ready to 1; an accepted request on an inactive tag sets active, remaining=s_req_bytes, offset=0, ctx=s_req_ctx.
REQ-018 SHALL drop a request that targets an already-active tag or has s_req_bytes==0, leave the entry unchanged, and set err_sticky.
REQ-019 SHALL assert s_cpl_ready iff (!m_cpl_valid || m_cpl_ready) && (!m_tag_free_valid || m_tag_free_ready).
REQ-020 SHALL present an accepted completion on the m_cpl_* outputs exactly one cycle after acceptance (registered, 1-cycle latency); full throughput is one completion per cycle.
REQ-021 SHALL, for a valid completion, output ctx, tag, offset as the pre-update entry value, and err=0; then set remaining-=bytes and offset+=bytes.
REQ-022 SHALL, when bytes==remaining, assert m_cpl_last=1, clear active, and load m_tag_free_data=tag, m_tag_free_valid=1 in the same cycle m_cpl_valid rises.
REQ-023 SHALL treat a completion to an inactive tag, or with bytes==0, or with bytes>remaining as an error: m_cpl_err=1, m_cpl_last=0, no entry update, no tag freed, err_sticky set.
REQ-024 SHALL hold m_cpl_* stable while m_cpl_valid && !m_cpl_ready, and hold m_tag_free_* stable while m_tag_free_valid && !m_tag_free_ready; the two handshakes are independent.
REQ-025 SHALL, when a request and a completion are accepted in the same cycle, apply both updates; the completion lookup uses the pre-request table state, so a request to the tag retired in that same cycle is an error (REQ-018).
REQ-026 SHALL increment outstanding on each accepted valid request and decrement it on each retire; simultaneous increment and decrement leave it unchanged; it never exceeds 2^PCIE_TAG_BITS.
REQ-027 SHALL not count m_cpl_err completions in outstanding or offset arithmetic; offset wraps modulo 2^BC_BITS (cannot occur when REQ-023 holds).

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), clear all active bits, outstanding=0, err_sticky=0, m_cpl_valid=0, m_tag_free_valid=0, and the other m_* outputs to 0.
REQ-029 SHALL discard all in-flight requests when reset is asserted mid-operation; no tag is freed for them after reset release.
REQ-030 SHALL accept completions from the first clk edge after rst_n deasserts.

Verification
REQ-031 SHALL pass: request tag 3, 256 bytes, ctx 0xABCD; completions of 64/128/64 bytes -> offsets 0/64/192, last only on the third, one free of tag 3, outstanding returns 1->0.
REQ-032 SHALL pass: completion to inactive tag 7 -> m_cpl_err=1, no m_tag_free_valid, err_sticky=1, outstanding unchanged.
REQ-033 SHALL pass: hold m_tag_free_ready=0 with a last completion pending -> s_cpl_ready=0 and outputs stable until ready rises.
REQ-034 SHALL pass: 32 requests (tags 0..31, 4 bytes each), then single completions in random order -> 32 frees, each tag exactly once, outstanding 32->0.
REQ-035 SHALL pass: request tag 5 in the same cycle as the last completion of tag 5 -> request dropped, err_sticky=1, tag 5 freed once.
REQ-036 SHALL pass: assert rst_n=0 with 4 tags active -> outstanding=0 immediately, no frees after release, new request to tag 0 accepted cleanly.
